step_clock_gen: RTL and testbench

STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

---
 rtl/step_clock_gen_if.sv | 24 ++
 rtl/step_clock_gen.sv | 132 +++++++++++++
 tb/tb_step_clock_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/step_clock_gen_if.sv
// Command/timing inputs and strobe outputs of the step clock generator.
interface step_clock_gen_if #(
  parameter int PW = 24
);
  logic          start;
  logic          stop;
  logic          pause;
  logic [PW-1:0] period;
  logic [PW-1:0] gate_len;
  logic          step_pulse;
  logic          bar_pulse;
  logic          gate;
  logic          running;

  modport master (
    output start, stop, pause, period, gate_len,
    input  step_pulse, bar_pulse, gate, running
  );

  modport slave (
    input  start, stop, pause, period, gate_len,
    output step_pulse, bar_pulse, gate, running
  );
endinterface

// File: rtl/step_clock_gen.sv
// Sequencer step clock: IDLE/RUN/PAUSE FSM producing step, bar and gate strobes,
// with period and gate length latched only at step boundaries.
module step_clock_gen #(
  parameter int PW            = 24,
  parameter int STEPS_PER_BAR = 8
) (
  input logic              clk,
  input logic              rst_n,
  step_clock_gen_if.slave  bus
);

  localparam int SW = (STEPS_PER_BAR > 1) ? $clog2(STEPS_PER_BAR) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(STEPS_PER_BAR - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]    state, state_d;
  logic [PW-1:0] phase, phase_d;
  logic [SW-1:0] step_idx, idx_d;
  logic [PW-1:0] period_q, per_d;
  logic [PW-1:0] gate_q, gq_d;
  logic          pulse_q, pulse_d;
  logic          bar_q, bar_d;
  logic          gate_r, gate_d;
  logic          run_q, run_d;

  // A step needs at least two cycles so the gate can drop before the next pulse.
  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
    return (p < PW'(2)) ? PW'(2) : p;
  endfunction

  function automatic logic [PW-1:0] clamp_gate(input logic [PW-1:0] g,
                                               input logic [PW-1:0] p);
    return (g > p - PW'(1)) ? p - PW'(1) : g;
  endfunction

  always_comb begin
    state_d = state;
    phase_d = phase;
    idx_d   = step_idx;
    per_d   = period_q;
    gq_d    = gate_q;
    pulse_d = 1'b0;
    bar_d   = 1'b0;
    gate_d  = 1'b0;
    run_d   = 1'b0;
    if (bus.stop) begin
      state_d = S_IDLE;
      phase_d = '0;
      idx_d   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.pause) begin
            state_d = S_RUN;
            phase_d = '0;
            idx_d   = '0;
            per_d   = clamp_period(bus.period);
            gq_d    = clamp_gate(bus.gate_len, per_d);
            pulse_d = 1'b1;
            bar_d   = 1'b1;
            gate_d  = (gq_d != '0);
            run_d   = 1'b1;
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (phase == period_q - PW'(1)) begin
            phase_d = '0;
            idx_d   = (step_idx == LAST_IDX) ? '0 : step_idx + SW'(1);
            per_d   = clamp_period(bus.period);
            gq_d    = clamp_gate(bus.gate_len, per_d);
            pulse_d = 1'b1;
            bar_d   = (idx_d == '0);
            gate_d  = (gq_d != '0);
            run_d   = 1'b1;
          end else begin
            phase_d = phase + PW'(1);
            gate_d  = (phase_d < gate_q);
            run_d   = 1'b1;
          end
        end
        S_PAUSE: begin
          // Resume continues the frozen step; the gate comes back if still inside it.
          if (bus.start && !bus.pause) begin
            state_d = S_RUN;
            gate_d  = (phase < gate_q);
            run_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      step_idx <= '0;
      period_q <= PW'(2);
      gate_q   <= '0;
      pulse_q  <= 1'b0;
      bar_q    <= 1'b0;
      gate_r   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      step_idx <= idx_d;
      period_q <= per_d;
      gate_q   <= gq_d;
      pulse_q  <= pulse_d;
      bar_q    <= bar_d;
      gate_r   <= gate_d;
      run_q    <= run_d;
    end
  end

  assign bus.step_pulse = pulse_q;
  assign bus.bar_pulse  = bar_q;
  assign bus.gate       = gate_r;
  assign bus.running    = run_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen: directed scenarios plus random commands,
// all cycles compared against a step-level behavioural model.
module tb_step_clock_gen;

  localparam int PW  = 8;
  localparam int SPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  step_clock_gen_if #(.PW(PW)) bus ();

  step_clock_gen #(.PW(PW), .STEPS_PER_BAR(SPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 run, 2 paused; pos = cycles into current step.
  int   m_mode = 0;
  int   m_pos  = 0;
  int   m_len  = 2;
  int   m_glen = 0;
  int   m_idx  = 0;
  logic e_run, e_sp, e_bar, e_gate;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_new_step(input int idx);
    int p, g;
    p = int'(bus.period);
    g = int'(bus.gate_len);
    m_pos  = 0;
    m_idx  = idx;
    m_len  = (p < 2) ? 2 : p;
    m_glen = (g < m_len) ? g : m_len - 1;
    e_sp   = 1'b1;
    e_bar  = (idx == 0);
    e_gate = (m_glen > 0);
    e_run  = 1'b1;
  endtask

  task automatic model_update();
    e_run = 1'b0; e_sp = 1'b0; e_bar = 1'b0; e_gate = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_len = 2; m_glen = 0; m_idx = 0;
    end else if (bus.stop) begin
      m_mode = 0; m_pos = 0; m_idx = 0;
    end else if (m_mode == 0) begin
      if (bus.start && !bus.pause) begin
        m_mode = 1;
        model_new_step(0);
      end
    end else if (m_mode == 1) begin
      if (bus.pause) begin
        m_mode = 2;
      end else begin
        m_pos++;
        if (m_pos == m_len) model_new_step((m_idx + 1) % SPB);
        else begin
          e_run  = 1'b1;
          e_gate = (m_pos < m_glen);
        end
      end
    end else if (bus.start && !bus.pause) begin
      m_mode = 1;
      e_run  = 1'b1;
      e_gate = (m_pos < m_glen);
    end
  endtask

  function automatic logic [3:0] dut_outs();
    return {bus.running, bus.step_pulse, bus.bar_pulse, bus.gate};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("outs", 32'(dut_outs()), 32'({e_run, e_sp, e_bar, e_gate}));
  endtask

  task automatic cmd(input logic s, input logic p, input logic t);
    bus.start = s; bus.pause = p; bus.stop = t;
  endtask

  task automatic go_idle();
    cmd(1'b0, 1'b0, 1'b1); tick();
    cmd(1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] v_sp, v_bar, v_gate, exp_v;
  logic [3:0]  any_out;
  int          wait_n;

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.period = 8'd4; bus.gate_len = 8'd2;

    // Reset asserted with no clock edge
    #2 rst_n = 1'b0;
    #1 chk("reset_outs", 32'(dut_outs()), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    // Stays idle after reset release until start
    for (int i = 0; i < 3; i++) tick();
    chk("idle_after_reset", 32'(dut_outs()), 32'd0);

    // Basic pattern: period 4, gate 2, four steps per bar
    bus.period = 8'd4; bus.gate_len = 8'd2;
    cmd(1'b1, 1'b0, 1'b0);
    v_sp = '0; v_bar = '0; v_gate = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cmd(1'b0, 1'b0, 1'b0);
      v_sp[i] = bus.step_pulse; v_bar[i] = bus.bar_pulse; v_gate[i] = bus.gate;
    end
    exp_v = '0; for (int i = 0; i < 20; i++) exp_v[i] = ((i % 4) == 0);
    chk("p4_step", v_sp, exp_v);
    exp_v = '0; for (int i = 0; i < 20; i++) exp_v[i] = ((i % 4) < 2);
    chk("p4_gate", v_gate, exp_v);
    exp_v = '0; exp_v[0] = 1'b1; exp_v[16] = 1'b1;
    chk("p4_bar", v_bar, exp_v);
    go_idle();

    // Mid-step period change takes effect only at the boundary
    bus.period = 8'd5; bus.gate_len = 8'd1;
    cmd(1'b1, 1'b0, 1'b0);
    v_sp = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cmd(1'b0, 1'b0, 1'b0);
      if (i == 1) bus.period = 8'd3;
      v_sp[i] = bus.step_pulse;
    end
    exp_v = '0; exp_v[0] = 1'b1; exp_v[5] = 1'b1; exp_v[8] = 1'b1; exp_v[11] = 1'b1;
    chk("period_change", v_sp, exp_v);
    go_idle();

    // Period clamp to 2, gate clamp to period-1
    bus.period = 8'd1; bus.gate_len = 8'd9;
    cmd(1'b1, 1'b0, 1'b0);
    v_sp = '0; v_gate = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmd(1'b0, 1'b0, 1'b0);
      v_sp[i] = bus.step_pulse; v_gate[i] = bus.gate;
    end
    exp_v = 32'h0000_0055;
    chk("clamp_step", v_sp, exp_v);
    chk("clamp_gate", v_gate, exp_v);
    go_idle();

    // Pause at phase 2 of a 6-cycle step, hold, resume
    bus.period = 8'd6; bus.gate_len = 8'd3;
    cmd(1'b1, 1'b0, 1'b0); tick();
    cmd(1'b0, 1'b0, 1'b0); tick(); tick();
    cmd(1'b0, 1'b1, 1'b0);
    any_out = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_out = any_out | dut_outs();
    end
    chk("pause_quiet", 32'(any_out), 32'd0);
    cmd(1'b1, 1'b0, 1'b0); tick();
    chk("resume_gate", 32'(bus.gate), 32'd1);
    chk("resume_nopulse", 32'(bus.step_pulse), 32'd0);
    cmd(1'b0, 1'b0, 1'b0);
    wait_n = 0;
    while (wait_n < 20) begin
      tick();
      wait_n++;
      if (bus.step_pulse) break;
    end
    chk("resume_to_pulse", 32'(wait_n), 32'd4);
    go_idle();

    // All commands at once while running: stop wins
    bus.period = 8'd3; bus.gate_len = 8'd2;
    cmd(1'b1, 1'b0, 1'b0); tick();
    cmd(1'b0, 1'b0, 1'b0); for (int i = 0; i < 4; i++) tick();
    cmd(1'b1, 1'b1, 1'b1); tick();
    chk("all_cmd_outs", 32'(dut_outs()), 32'd0);
    cmd(1'b1, 1'b0, 1'b0); tick();
    chk("restart_bar", 32'(bus.bar_pulse), 32'd1);
    cmd(1'b0, 1'b0, 1'b0);
    go_idle();

    // Asynchronous reset mid-gate
    bus.period = 8'd8; bus.gate_len = 8'd5;
    cmd(1'b1, 1'b0, 1'b0); tick();
    cmd(1'b0, 1'b0, 1'b0); tick(); tick();
    chk("pre_reset_gate", 32'(bus.gate), 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 32'(dut_outs()), 32'd0);
    model_update();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmd(1'b1, 1'b0, 1'b0); tick();
    chk("post_reset_step", 32'(bus.step_pulse), 32'd1);
    chk("post_reset_bar", 32'(bus.bar_pulse), 32'd1);
    cmd(1'b0, 1'b0, 1'b0);

    // Random commands and timing changes
    for (int i = 0; i < 1500; i++) begin
      bus.stop  = ($urandom_range(0, 39) == 0);
      bus.pause = ($urandom_range(0, 11) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) bus.period   = 8'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) bus.gate_len = 8'($urandom_range(0, 12));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
